// File: rtl/clock_divider_prog.sv
// Multi-channel programmable clock divider: per-channel divided clock-enable and
// period-start tick, with glitch-free configuration updates at period boundaries.
module clock_divider_prog #(
   parameter int NUM_CH   = 2,
   parameter int CNT_W    = 8,
   parameter int RST_DIV  = 3,
   parameter int RST_HIGH = 2
) (
   input  logic                      clk_in,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         en,
   input  logic                      sync,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [NUM_CH*CNT_W-1:0]   div_cfg,
   input  logic [NUM_CH*CNT_W-1:0]   high_cfg,
   output logic [NUM_CH-1:0]         clk_out,
   output logic [NUM_CH-1:0]         tick
);

   logic [NUM_CH-1:0] pend_q;
   logic              xfer;

   assign cfg_ready = ~|pend_q;
   assign xfer      = cfg_valid & cfg_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [CNT_W-1:0] count_q, count_d;
         logic [CNT_W-1:0] act_div_q, act_div_d;
         logic [CNT_W-1:0] act_high_q, act_high_d;
         logic [CNT_W-1:0] pend_div_q, pend_high_q;
         logic             pend_flag_q, pend_flag_d;
         logic             running_q, running_d;
         logic             clk_q, clk_d;
         logic             tick_q, tick_d;
         logic [CNT_W-1:0] new_div, new_high;
         logic [CNT_W:0]   count_inc;

         always_comb begin
            new_div     = pend_flag_q ? pend_div_q  : act_div_q;
            new_high    = pend_flag_q ? pend_high_q : act_high_q;
            count_inc   = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
            running_d   = running_q;
            count_d     = count_q;
            clk_d       = clk_q;
            tick_d      = tick_q;
            act_div_d   = act_div_q;
            act_high_d  = act_high_q;
            pend_flag_d = pend_flag_q;

            if (!en[gi]) begin
               running_d   = 1'b0;
               count_d     = '0;
               clk_d       = 1'b0;
               tick_d      = 1'b0;
               act_div_d   = new_div;
               act_high_d  = new_high;
               pend_flag_d = 1'b0;
            end else if (!running_q || sync || (count_q == act_div_q)) begin
               // Period start: the only place a new configuration may take effect.
               running_d   = 1'b1;
               count_d     = '0;
               tick_d      = 1'b1;
               clk_d       = (new_high != '0);
               act_div_d   = new_div;
               act_high_d  = new_high;
               pend_flag_d = 1'b0;
            end else begin
               count_d = count_inc[CNT_W-1:0];
               tick_d  = 1'b0;
               clk_d   = (count_inc < {1'b0, act_high_q});
            end

            // Pending flag is clear whenever a transfer happens, so setting wins.
            if (xfer) begin
               pend_flag_d = 1'b1;
            end
         end

         always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
               count_q     <= '0;
               running_q   <= 1'b0;
               clk_q       <= 1'b0;
               tick_q      <= 1'b0;
               act_div_q   <= CNT_W'(RST_DIV);
               act_high_q  <= CNT_W'(RST_HIGH);
               pend_div_q  <= '0;
               pend_high_q <= '0;
               pend_flag_q <= 1'b0;
            end else begin
               count_q     <= count_d;
               running_q   <= running_d;
               clk_q       <= clk_d;
               tick_q      <= tick_d;
               act_div_q   <= act_div_d;
               act_high_q  <= act_high_d;
               pend_flag_q <= pend_flag_d;
               if (xfer) begin
                  pend_div_q  <= div_cfg[gi*CNT_W +: CNT_W];
                  pend_high_q <= high_cfg[gi*CNT_W +: CNT_W];
               end
            end
         end

         assign pend_q[gi]  = pend_flag_q;
         assign clk_out[gi] = clk_q;
         assign tick[gi]    = tick_q;
      end
   endgenerate

endmodule

// File: tb/tb_clock_divider_prog.sv
// Scoreboard bench for clock_divider_prog: a cycle model pushes expected outputs
// per edge; they are popped and compared one cycle later against the DUT.
module tb_clock_divider_prog;

   logic        clk_in = 1'b0;
   logic        rst;
   logic [1:0]  en;
   logic        sync;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [15:0] div_cfg;
   logic [15:0] high_cfg;
   logic [1:0]  clk_out;
   logic [1:0]  tick;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [4:0] exp_q[$];

   int m_cnt[2], m_div[2], m_high[2], m_pdiv[2], m_phigh[2];
   bit m_run[2], m_pend[2];

   clock_divider_prog #(.NUM_CH(2), .CNT_W(8), .RST_DIV(3), .RST_HIGH(2)) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .en        (en),
      .sync      (sync),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .div_cfg   (div_cfg),
      .high_cfg  (high_cfg),
      .clk_out   (clk_out),
      .tick      (tick)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit model_ready();
      return !(m_pend[0] || m_pend[1]);
   endfunction

   task automatic model_reset();
      for (int ch = 0; ch < 2; ch++) begin
         m_cnt[ch]  = 0;
         m_run[ch]  = 0;
         m_div[ch]  = 3;
         m_high[ch] = 2;
         m_pend[ch] = 0;
      end
   endtask

   // One clock edge: predict, push, then compare the popped expectation.
   task automatic step();
      bit         rdy;
      logic [4:0] e;
      logic [4:0] got;
      rdy = model_ready();
      for (int ch = 0; ch < 2; ch++) begin
         int nd, nh;
         nd = m_pend[ch] ? m_pdiv[ch]  : m_div[ch];
         nh = m_pend[ch] ? m_phigh[ch] : m_high[ch];
         if (!en[ch]) begin
            m_run[ch] = 0;
            m_cnt[ch] = 0;
            m_div[ch] = nd; m_high[ch] = nh; m_pend[ch] = 0;
         end else if (!m_run[ch] || sync || m_cnt[ch] == m_div[ch]) begin
            m_run[ch] = 1;
            m_cnt[ch] = 0;
            m_div[ch] = nd; m_high[ch] = nh; m_pend[ch] = 0;
         end else begin
            m_cnt[ch]++;
         end
      end
      if (cfg_valid && rdy) begin
         for (int ch = 0; ch < 2; ch++) begin
            m_pend[ch]  = 1;
            m_pdiv[ch]  = int'(div_cfg[ch*8 +: 8]);
            m_phigh[ch] = int'(high_cfg[ch*8 +: 8]);
         end
      end
      e[4] = model_ready();
      for (int ch = 0; ch < 2; ch++) begin
         e[2+ch] = m_run[ch] && (m_cnt[ch] == 0);
         e[ch]   = m_run[ch] && (m_cnt[ch] < m_high[ch]);
      end
      exp_q.push_back(e);

      @(posedge clk_in);
      #1;
      cyc++;
      e   = exp_q.pop_front();
      got = {cfg_ready, tick, clk_out};
      check($sformatf("cyc%0d {ready,tick,clk}", cyc), 32'(got), 32'(e));
      $display("cyc %0d en=%b sync=%b valid=%b ready=%b tick=%b clk_out=%b", cyc, en, sync,
               cfg_valid, cfg_ready, tick, clk_out);
      @(negedge clk_in);
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic do_cfg(input logic [15:0] d, input logic [15:0] h);
      bit taken;
      taken     = 0;
      cfg_valid = 1'b1;
      div_cfg   = d;
      high_cfg  = h;
      for (int k = 0; k < 60 && !taken; k++) begin
         taken = model_ready();
         step();
      end
      cfg_valid = 1'b0;
      check("cfg_accept", 32'(taken), 32'd1);
   endtask

   task automatic wait_cnt0(input int target);
      bit hit;
      hit = 0;
      for (int k = 0; k < 40 && !hit; k++) begin
         if (m_cnt[0] == target) hit = 1;
         else step();
      end
      check($sformatf("reach_cnt%0d", target), 32'(hit), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      en        = 2'b00;
      sync      = 1'b0;
      cfg_valid = 1'b0;
      div_cfg   = '0;
      high_cfg  = '0;
      model_reset();
      #1;
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_ready", 32'(cfg_ready), 32'd1);
      @(negedge clk_in);
      @(negedge clk_in);
      rst = 1'b0;

      // Defaults on channel 0 only
      en = 2'b01;
      steps(10);

      // Mid-period transfer, then a second offer while busy must be ignored
      wait_cnt0(1);
      do_cfg({8'd3, 8'd4}, {8'd2, 8'd1});
      cfg_valid = 1'b1;
      div_cfg   = {8'd7, 8'd7};
      high_cfg  = {8'd7, 8'd7};
      step();
      cfg_valid = 1'b0;
      steps(14);

      // HIGH=0, HIGH>DIV, DIV=0
      do_cfg({8'd3, 8'd4}, {8'd2, 8'd0});
      steps(12);
      do_cfg({8'd3, 8'd4}, {8'd2, 8'd9});
      steps(12);
      do_cfg({8'd3, 8'd0}, {8'd2, 8'd1});
      steps(6);

      // Two channels, sync mid-period
      en = 2'b11;
      do_cfg({8'd6, 8'd3}, {8'd2, 8'd2});
      steps(6);
      sync = 1'b1;
      step();
      sync = 1'b0;
      steps(10);

      // Transfer on a boundary edge, then async reset while clk_out[0]=1 and pending
      wait_cnt0(3);
      do_cfg({8'd6, 8'd5}, {8'd2, 8'd4});
      check("pre_rst_ready", 32'(cfg_ready), 32'd0);
      #1 rst = 1'b1;
      #1;
      check("async_rst_clk_out", 32'(clk_out), 32'd0);
      check("async_rst_tick", 32'(tick), 32'd0);
      check("async_rst_ready", 32'(cfg_ready), 32'd1);
      model_reset();
      @(posedge clk_in);
      @(negedge clk_in);
      rst = 1'b0;
      steps(10);

      // Disable channel 0 for three cycles, then re-enable
      en = 2'b10;
      steps(3);
      en = 2'b11;
      steps(6);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
